// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit.
// One radix-2 step per cycle (shift-add multiply, restoring divide), fixed
// WIDTH+1 cycle latency from the accepting edge to the HI/LO update.
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a, b : operation request
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only in IDLE without start
//   busy, done, div_by_zero : registered status
//   hi, lo : registered HI/LO results
module mips_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             accept, step, finish;
   logic [CW-1:0]    cnt_q;
   logic             is_div_q, neg_a_q, neg_b_q;
   logic [WIDTH-1:0] a_q, mag_a_q, mag_b_q;
   // Shared accumulator: product {hi,lo} for multiply, {remainder,quotient} for divide.
   logic [WIDTH-1:0] p_hi_q, p_lo_q;

   logic             neg_a_c, neg_b_c;
   logic [WIDTH-1:0] mag_a_c, mag_b_c;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             res_dz;

   // Next-state and step strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
         end
         FIN: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand magnitudes; op[0]=1 selects the unsigned variants
   always_comb begin
      neg_a_c = ~op[0] & a[WIDTH-1];
      neg_b_c = ~op[0] & b[WIDTH-1];
      mag_a_c = neg_a_c ? -a : a;
      mag_b_c = neg_b_c ? -b : b;
   end

   // One multiply/divide step
   always_comb begin
      addend    = p_lo_q[0] ? mag_a_q : '0;
      mul_sum   = {1'b0, p_hi_q} + {1'b0, addend};
      div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, mag_b_q};
      // True difference is below 2^WIDTH whenever div_ge holds
      div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
   end

   // Sign correction and divide-by-zero override for the final write
   always_comb begin
      prod     = {p_hi_q, p_lo_q};
      prod_neg = -prod;
      res_dz   = 1'b0;
      if (!is_div_q) begin
         {res_hi, res_lo} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
      end else if (mag_b_q == '0) begin
         res_hi = a_q;
         res_lo = '1;
         res_dz = 1'b1;
      end else begin
         res_lo = (neg_a_q ^ neg_b_q) ? -p_lo_q : p_lo_q;
         res_hi = neg_a_q ? -p_hi_q : p_hi_q;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         a_q         <= '0;
         mag_a_q     <= '0;
         mag_b_q     <= '0;
         p_hi_q      <= '0;
         p_lo_q      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         state_q <= state_d;
         done    <= finish;

         if (accept) begin
            is_div_q    <= op[1];
            neg_a_q     <= neg_a_c;
            neg_b_q     <= neg_b_c;
            a_q         <= a;
            mag_a_q     <= mag_a_c;
            mag_b_q     <= mag_b_c;
            cnt_q       <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= op[1] ? mag_a_c : mag_b_c;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
         end

         if (step) begin
            cnt_q <= cnt_q + CW'(1);
            if (is_div_q) begin
               p_hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
               p_lo_q <= {p_lo_q[WIDTH-2:0], div_ge};
            end else begin
               p_hi_q <= mul_sum[WIDTH:1];
               p_lo_q <= {mul_sum[0], p_lo_q[WIDTH-1:1]};
            end
         end

         if (finish) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= res_dz;
            busy        <= 1'b0;
         end

         // MTHI/MTLO only when idle and no operation is being accepted
         if (state_q == IDLE && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed table, random ops against an arithmetic model,
// and hand-written sequences for busy/start/MTHI interaction and mid-op reset.
module tb_mips_muldiv;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         hi_we, lo_we;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int npass  = 0;
   int ntotal = 0;

   mips_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: plain arithmetic on the architectural definition
   function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
      longint      lx, ly, lp;
      logic [63:0] p;
      int          sx, sy;
      ed = 1'b0;
      eh = '0;
      el = '0;
      case (o)
         2'd0: begin
            lx = longint'($signed(x));
            ly = longint'($signed(y));
            lp = lx * ly;
            p  = 64'(lp);
            {eh, el} = p;
         end
         2'd1: begin
            p = {32'b0, x} * {32'b0, y};
            {eh, el} = p;
         end
         2'd2: begin
            if (y == 0) begin
               eh = x; el = '1; ed = 1'b1;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               eh = '0; el = 32'h8000_0000;
            end else begin
               sx = $signed(x);
               sy = $signed(y);
               el = 32'(sx / sy);
               eh = 32'(sx % sy);
            end
         end
         default: begin
            if (y == 0) begin
               eh = x; el = '1; ed = 1'b1;
            end else begin
               el = x / y;
               eh = x % y;
            end
         end
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic run_check(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input logic ed);
      int n;
      issue(o, x, y);
      chk({tag, ".busy_on"}, 64'(busy), 64'(1));
      chk({tag, ".dz_cleared"}, 64'(div_by_zero), 64'(0));
      wait_done(n);
      chk({tag, ".latency"}, 64'(n), 64'(LAT));
      chk({tag, ".hi"}, 64'(hi), 64'(eh));
      chk({tag, ".lo"}, 64'(lo), 64'(el));
      chk({tag, ".dz"}, 64'(div_by_zero), 64'(ed));
      chk({tag, ".busy_off"}, 64'(busy), 64'(0));
      tick();
      chk({tag, ".done_1cyc"}, 64'(done), 64'(0));
      chk({tag, ".dz_hold"}, 64'(div_by_zero), 64'(ed));
   endtask

   initial begin
      vec_t         vecs[$];
      logic [W-1:0] eh, el, prev_hi;
      logic         ed;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      int           n, dcount;

      vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
      vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
      vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
      vecs.push_back('{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0});
      vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
      vecs.push_back('{2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1});

      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      #12;
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.done", 64'(done), 64'(0));
      chk("rst.dz", 64'(div_by_zero), 64'(0));
      chk("rst.hi", 64'(hi), 64'(0));
      chk("rst.lo", 64'(lo), 64'(0));
      tick();
      reset = 1'b1;
      tick();

      // Directed table; the last entry (DIVU by zero) leaves div_by_zero set
      foreach (vecs[i])
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);

      // Flag persists in IDLE, then the next accepted start clears it
      tick(); tick(); tick();
      chk("dz.idle_hold", 64'(div_by_zero), 64'(1));
      run_check("dz.clear_mulu", 2'd1, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0000_000C, 1'b0);

      // Random ops against the model
      for (int i = 0; i < 150; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom();
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom();
         endcase
         model(ro, ra, rb, eh, el, ed);
         run_check($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed);
      end

      // Start and MTHI during busy are ignored; HI shows previous result during RUN
      prev_hi = hi;
      model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, ed);
      issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      tick(); tick(); tick(); tick();
      start = 1'b1; op = 2'd2; a = 32'h0000_0010; b = 32'h0000_0003;
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; hi_we = 1'b0;
      chk("busy_start.hi_hold", 64'(hi), 64'(prev_hi));
      chk("busy_start.busy", 64'(busy), 64'(1));
      wait_done(n);
      chk("busy_start.latency", 64'(n), 64'(LAT - 5));
      chk("busy_start.hi", 64'(hi), 64'(eh));
      chk("busy_start.lo", 64'(lo), 64'(el));
      tick();
      chk("busy_start.no_second", 64'(busy), 64'(0));

      // Reset in the middle of a DIV
      issue(2'd2, 32'h7FFF_0000, 32'h0000_0013);
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b0;
      #1;
      chk("midrst.busy", 64'(busy), 64'(0));
      chk("midrst.done", 64'(done), 64'(0));
      chk("midrst.hi", 64'(hi), 64'(0));
      chk("midrst.lo", 64'(lo), 64'(0));
      tick(); tick();
      reset = 1'b1;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) dcount++;
      end
      chk("midrst.no_done", 64'(dcount), 64'(0));
      chk("midrst.idle", 64'(busy), 64'(0));
      lo_we = 1'b1; wdata = 32'h0000_ABCD;
      tick();
      lo_we = 1'b0;
      chk("mtlo.lo", 64'(lo), 64'(32'h0000_ABCD));
      chk("mtlo.hi", 64'(hi), 64'(0));

      // MTHI together with an accepted start is dropped
      hi_we = 1'b1; wdata = 32'h0000_1234;
      issue(2'd1, 32'h0000_0003, 32'h0000_0004);
      hi_we = 1'b0;
      chk("mthi_start.hi", 64'(hi), 64'(0));
      chk("mthi_start.lo", 64'(lo), 64'(32'h0000_ABCD));
      wait_done(n);
      chk("mthi_start.res_lo", 64'(lo), 64'(32'h0000_000C));
      tick();

      // MTHI in IDLE
      hi_we = 1'b1; wdata = 32'h5555_AAAA;
      tick();
      hi_we = 1'b0;
      chk("mthi.hi", 64'(hi), 64'(32'h5555_AAAA));
      chk("mthi.lo", 64'(lo), 64'(32'h0000_000C));

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 Parameter WIDTH, 32, operand/HI/LO width; legal range 4..64.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain (clk) only.
REQ-004 start  input  1  request a new operation; sampled on posedge clk.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  multiplicand or dividend (rs value).
REQ-007 b  input  WIDTH  multiplier or divisor (rt value).
REQ-008 hi_we  input  1  MTHI strobe; loads wdata into HI.
REQ-009 lo_we  input  1  MTLO strobe; loads wdata into LO.
REQ-010 wdata  input  WIDTH  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress; registered.
REQ-012 done  output  1  single-cycle completion pulse; registered.
REQ-013 div_by_zero  output  1  set with done when DIV/DIVU had b==0; held until the next accepted start.
REQ-014 hi  output  WIDTH  HI register (MFHI source); registered, combinationally readable.
REQ-015 lo  output  WIDTH  LO register (MFLO source); registered, combinationally readable.

Function
REQ-016 FSM states: IDLE, RUN, FIN; reset state IDLE.
REQ-017 IDLE: start=1 at edge E0 -> latch op/a/b, take operand magnitudes for signed ops, clear iteration counter, clear div_by_zero, go RUN, busy=1.
REQ-018 RUN: one radix-2 step per cycle (shift-add multiply / restoring divide) for exactly WIDTH cycles; then FIN.
REQ-019 FIN: apply sign correction, write HI/LO at edge E(WIDTH+1), busy=0 and done=1 for the cycle after that edge, return IDLE.
REQ-020 Latency is fixed at WIDTH+1 cycles from the accepting edge to the HI/LO update for all ops, including divide-by-zero.
REQ-021 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product, two's complement for MULT.
REQ-022 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-023 Divide by zero: LO = all ones, HI = a, div_by_zero=1 with done.
REQ-024 DIV most-negative / -1: LO = most-negative value, HI = 0, no flag.
REQ-025 start while busy=1 is ignored; no queuing, no effect on the running operation.
REQ-026 hi_we/lo_we in IDLE with start=0 update HI/LO at that edge.
REQ-027 hi_we/lo_we while busy=1, or in the same cycle as an accepted start, are ignored.
REQ-028 HI/LO hold their values between writes; during RUN they show the previous result, not partial values.
REQ-029 Iteration counter width is clog2(WIDTH)+1; no wrap within one operation.

Reset
REQ-030 reset low at any time, including mid-RUN/FIN, immediately forces IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and discards internal operand/accumulator state.
REQ-031 An operation aborted by reset produces no done pulse; the first start after reset release begins a fresh operation.

Verification (WIDTH=32)
REQ-032 MULT a=FFFFFFFD, b=00000005 -> 33 cycles later hi=FFFFFFFF, lo=FFFFFFF1, done pulse one cycle wide.
REQ-033 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-034 DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-035 DIVU a=00000064, b=0 -> hi=00000064, lo=FFFFFFFF, div_by_zero=1; a following MULTU start clears div_by_zero.
REQ-036 Second start with different op at cycle 5 of a MULTU -> ignored; the first result is correct; hi_we during busy leaves HI unchanged.
REQ-037 reset asserted at cycle 10 of a DIV -> hi=lo=0, busy=0, no done pulse; after release, MTLO 0000ABCD in IDLE -> lo=0000ABCD next cycle.
